// File: rtl/btn_pkg.sv
// Shared definitions for the button path: front-end debouncer and edge-pulse stage.
package btn_pkg;

    localparam int MS_PER_S  = 1000;
    localparam int DB_MS_DEF = 20;

    // Bits needed to hold values 0..v-1; constant-folded at elaboration.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: two-flop synchroniser plus tick-driven debounce counter.
module btn_db_chan
    import btn_pkg::*;
#(
    parameter int DB_MS = DB_MS_DEF,
    parameter int DCW   = clog2(DB_MS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic db,
    output logic chg
);

    logic           s1_q, s2_q;
    logic           db_q, db_d;
    logic           chg_q, chg_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        db_d   = db_q;
        chg_d  = 1'b0;
        if (tick) begin
            if (s2_q == db_q) begin
                // Agreement (including a bounce back) restarts the count.
                dcnt_d = '0;
            end else if (dcnt_q == DCW'(DB_MS - 1)) begin
                db_d   = s2_q;
                dcnt_d = '0;
                chg_d  = 1'b1;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            chg_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            db_q   <= db_d;
            chg_q  <= chg_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign db  = db_q;
    assign chg = chg_q;

endmodule

// File: rtl/btn_debounce.sv
// Button front end: 1 ms tick prescaler and N_BTN independent debounce channels.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int F_CLK = 50_000_000,
    parameter int N_BTN = 4,
    parameter int DB_MS = DB_MS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             ce1ms,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_chg
);

    localparam int DIV = F_CLK / MS_PER_S;
    localparam int PW  = clog2(DIV);
    localparam int DCW = clog2(DB_MS + 1);

    if ((F_CLK % MS_PER_S) != 0 || F_CLK < 2 * MS_PER_S ||
        DB_MS < 1 || DB_MS > 255 || N_BTN < 1 || N_BTN > 16) begin : g_param_err
        $error("btn_debounce: illegal parameter set");
    end

    logic [PW-1:0] cnt_q, cnt_d;
    logic          ce_q, ce_d;

    // Tick is registered off the terminal count so it is a clean one-clk pulse.
    always_comb begin
        cnt_d = (cnt_q == PW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        ce_d  = (cnt_q == PW'(DIV - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce1ms = ce_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_db_chan #(
            .DB_MS (DB_MS),
            .DCW   (DCW)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .tick (ce_q),
            .raw  (btn_raw[i]),
            .db   (btn_db[i]),
            .chg  (btn_chg[i])
        );
    end

endmodule
